pipe_hazard_ctrl: RTL and testbench

Central stall/flush/req sequencer for the 5-stage pipeline; drives the stall, flush and req inputs of the FD, DE, EM and MW pipeline registers and the PC enable.
Detects register-file RAW hazards from Tuse/Tnew, HI/LO/MDU busy hazards, and the ERET-after-MTC0-EPC hazard.
Tracks multiply/divide unit occupancy with an internal countdown.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 15 +
 rtl/pipe_hazard_ctrl_if.sv | 43 ++++
 rtl/pipe_hazard_ctrl_md_busy_counter.sv | 41 ++++
 rtl/pipe_hazard_ctrl.sv | 78 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [4:0] CP0_EPC = 5'd14;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF = 10;

    // A producer stalls the consumer when its result arrives later than it is needed.
    function automatic logic raw_hit(logic we, logic [4:0] wn, logic [4:0] src,
                                     logic [1:0] tnew, logic [1:0] tuse);
        return we && (wn == src) && (src != 5'd0) && (tuse != TUSE_NONE) && (tnew > tuse);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle: stage hazard inputs from the pipeline, stall/flush/req back to it.
interface pipe_hazard_ctrl_if;

    logic [4:0] D_rs;
    logic [4:0] D_rt;
    logic [1:0] D_Tuse_rs;
    logic [1:0] D_Tuse_rt;
    logic       D_uses_md;
    logic       D_eret;
    logic [4:0] E_REG_write_number;
    logic       E_REG_write_enable;
    logic [1:0] E_Tnew;
    logic       E_mtc0_epc;
    logic       E_md_start;
    logic       E_md_is_div;
    logic [4:0] M_REG_write_number;
    logic       M_REG_write_enable;
    logic [1:0] M_Tnew;
    logic       M_mtc0_epc;
    logic       M_exc_req;
    logic       PC_en;
    logic       FD_stall;
    logic       DE_flush;
    logic       req;
    logic       md_busy;

    modport master (
        output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_uses_md, D_eret,
        output E_REG_write_number, E_REG_write_enable, E_Tnew, E_mtc0_epc,
        output E_md_start, E_md_is_div,
        output M_REG_write_number, M_REG_write_enable, M_Tnew, M_mtc0_epc, M_exc_req,
        input  PC_en, FD_stall, DE_flush, req, md_busy
    );

    modport slave (
        input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_uses_md, D_eret,
        input  E_REG_write_number, E_REG_write_enable, E_Tnew, E_mtc0_epc,
        input  E_md_start, E_md_is_div,
        input  M_REG_write_number, M_REG_write_enable, M_Tnew, M_mtc0_epc, M_exc_req,
        output PC_en, FD_stall, DE_flush, req, md_busy
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// Multiply/divide unit occupancy countdown; busy is asserted in the start cycle itself.
module pipe_hazard_ctrl_md_busy_counter #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    input  logic req,
    output logic md_busy
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             load;

    // A flushed start never issues; a running op is not aborted by req.
    assign load = start & ~req;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign md_busy = (count_q != '0) | load;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush/req sequencer. Optional perf counters with PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                clk,
    input  logic                reset,
    pipe_hazard_ctrl_if.slave   bus
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]         perf_stall_cycles,
    output logic [31:0]         perf_req_count
`endif
);

    logic md_busy;
    logic stall_raw;
    logic stall_md;
    logic stall_eret;
    logic stall;
    logic req;

    assign req = bus.M_exc_req;

    pipe_hazard_ctrl_md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_counter (
        .clk     (clk),
        .reset   (reset),
        .start   (bus.E_md_start),
        .is_div  (bus.E_md_is_div),
        .req     (req),
        .md_busy (md_busy)
    );

    always_comb begin
        stall_raw = raw_hit(bus.E_REG_write_enable, bus.E_REG_write_number, bus.D_rs,
                            bus.E_Tnew, bus.D_Tuse_rs)
                  | raw_hit(bus.E_REG_write_enable, bus.E_REG_write_number, bus.D_rt,
                            bus.E_Tnew, bus.D_Tuse_rt)
                  | raw_hit(bus.M_REG_write_enable, bus.M_REG_write_number, bus.D_rs,
                            bus.M_Tnew, bus.D_Tuse_rs)
                  | raw_hit(bus.M_REG_write_enable, bus.M_REG_write_number, bus.D_rt,
                            bus.M_Tnew, bus.D_Tuse_rt);
        stall_md   = bus.D_uses_md & md_busy;
        // EPC written in flight would be read stale by ERET in D.
        stall_eret = bus.D_eret & (bus.E_mtc0_epc | bus.M_mtc0_epc);
        stall      = stall_raw | stall_md | stall_eret;
    end

    assign bus.req      = req;
    assign bus.PC_en    = ~stall | req;
    assign bus.FD_stall = stall & ~req;
    assign bus.DE_flush = stall & ~req;
    assign bus.md_busy  = md_busy;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_req_count    <= '0;
        end else begin
            if (stall & ~req) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (req) begin
                perf_req_count <= perf_req_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed literal checks plus randomized model compare.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   md_end = -1;
    bit   chk_en = 1'b0;

    pipe_hazard_ctrl_if bus ();

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_req_count;
`endif

    pipe_hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_req_count    (perf_req_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: MDU is busy through absolute cycle md_end, or now if a start is accepted.
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or negedge reset) begin
        if (!reset) md_end <= -1;
        else if (bus.E_md_start && !bus.M_exc_req) md_end <= cyc + (bus.E_md_is_div ? 10 : 5);
    end

    function automatic bit src_hazard(input int src, input int tuse);
        bit h = 0;
        if (src == 0 || tuse == 3) return 0;
        if (bus.E_REG_write_enable && int'(bus.E_REG_write_number) == src &&
            int'(bus.E_Tnew) > tuse) h = 1;
        if (bus.M_REG_write_enable && int'(bus.M_REG_write_number) == src &&
            int'(bus.M_Tnew) > tuse) h = 1;
        return h;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            bit busy_e, stall_e, req_e;
            req_e   = bus.M_exc_req;
            busy_e  = reset && ((cyc <= md_end) || (bus.E_md_start && !req_e));
            stall_e = src_hazard(int'(bus.D_rs), int'(bus.D_Tuse_rs))
                   || src_hazard(int'(bus.D_rt), int'(bus.D_Tuse_rt))
                   || (bus.D_uses_md && busy_e)
                   || (bus.D_eret && (bus.E_mtc0_epc || bus.M_mtc0_epc));
            chk("model_md_busy", int'(bus.md_busy), int'(busy_e));
            chk("model_req", int'(bus.req), int'(req_e));
            chk("model_PC_en", int'(bus.PC_en), int'(!stall_e || req_e));
            chk("model_FD_stall", int'(bus.FD_stall), int'(stall_e && !req_e));
            chk("model_DE_flush", int'(bus.DE_flush), int'(stall_e && !req_e));
        end
    end

    task automatic drive_idle();
        bus.D_rs = 0; bus.D_rt = 0; bus.D_Tuse_rs = 3; bus.D_Tuse_rt = 3;
        bus.D_uses_md = 0; bus.D_eret = 0;
        bus.E_REG_write_number = 0; bus.E_REG_write_enable = 0; bus.E_Tnew = 0;
        bus.E_mtc0_epc = 0; bus.E_md_start = 0; bus.E_md_is_div = 0;
        bus.M_REG_write_number = 0; bus.M_REG_write_enable = 0; bus.M_Tnew = 0;
        bus.M_mtc0_epc = 0; bus.M_exc_req = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic md_run(input bit is_div, input string tag, input int exp_busy);
        int busy_cnt, first_free;
        next();
        drive_idle();
        bus.D_uses_md = 1; bus.E_md_start = 1; bus.E_md_is_div = is_div;
        #1;
        busy_cnt = int'(bus.md_busy);
        first_free = -1;
        chk({tag, "_start_stall"}, int'(bus.FD_stall), 1);
        for (int i = 1; i <= 15; i++) begin
            next();
            bus.E_md_start = 0;
            #1;
            if (bus.md_busy) busy_cnt++;
            else if (first_free < 0) first_free = i;
            if (i == exp_busy) chk({tag, "_stall_end"}, int'(bus.FD_stall), 0);
        end
        chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        chk({tag, "_free_cycle"}, first_free, exp_busy);
    endtask

    initial begin
        drive_idle();
        #2;
        chk("reset_PC_en", int'(bus.PC_en), 1);
        chk("reset_FD_stall", int'(bus.FD_stall), 0);
        chk("reset_DE_flush", int'(bus.DE_flush), 0);
        chk("reset_req", int'(bus.req), 0);
        chk("reset_md_busy", int'(bus.md_busy), 0);
        chk_en = 1;
        #10 reset = 1;

        // Load-use hazard on rs
        next();
        bus.E_REG_write_number = 5; bus.E_REG_write_enable = 1; bus.E_Tnew = 2;
        bus.D_rs = 5; bus.D_Tuse_rs = 1;
        #1;
        chk("loaduse_FD_stall", int'(bus.FD_stall), 1);
        chk("loaduse_DE_flush", int'(bus.DE_flush), 1);
        chk("loaduse_PC_en", int'(bus.PC_en), 0);
        bus.D_rs = 0;
        #1;
        chk("loaduse_r0_stall", int'(bus.FD_stall), 0);

        // M-stage on rt
        next();
        drive_idle();
        bus.M_REG_write_number = 7; bus.M_REG_write_enable = 1; bus.M_Tnew = 0;
        bus.D_rt = 7; bus.D_Tuse_rt = 0;
        #1;
        chk("m_fwd_stall", int'(bus.FD_stall), 0);
        bus.M_Tnew = 1;
        #1;
        chk("m_late_stall", int'(bus.FD_stall), 1);
        next();
        bus.M_exc_req = 1;
        #1;
        chk("req_prio_req", int'(bus.req), 1);
        chk("req_prio_FD_stall", int'(bus.FD_stall), 0);
        chk("req_prio_PC_en", int'(bus.PC_en), 1);

        md_run(1'b1, "div", 11);
        md_run(1'b0, "mult", 6);

        // req coincident with MDU start: no load
        next();
        drive_idle();
        bus.E_md_start = 1; bus.E_md_is_div = 1; bus.M_exc_req = 1;
        #1;
        chk("req_start_busy", int'(bus.md_busy), 0);
        next();
        drive_idle();
        #1;
        chk("req_start_after", int'(bus.md_busy), 0);

        // ERET after MTC0 EPC in E then M
        next();
        bus.D_eret = 1; bus.E_mtc0_epc = 1;
        #1;
        chk("eret_E_stall", int'(bus.FD_stall), 1);
        next();
        bus.E_mtc0_epc = 0; bus.M_mtc0_epc = 1;
        #1;
        chk("eret_M_stall", int'(bus.FD_stall), 1);
        next();
        bus.M_mtc0_epc = 0;
        #1;
        chk("eret_clear", int'(bus.FD_stall), 0);

        // Async reset at count 7
        next();
        drive_idle();
        bus.E_md_start = 1; bus.E_md_is_div = 1;
        for (int i = 0; i < 4; i++) begin
            next();
            bus.E_md_start = 0;
        end
        chk("mid_div_busy", int'(bus.md_busy), 1);
        reset = 0;
        #1;
        chk("async_reset_busy", int'(bus.md_busy), 0);
        #1 reset = 1;

        for (int n = 0; n < 3000; n++) begin
            next();
            bus.D_rs = 5'($urandom_range(0, 3));
            bus.D_rt = 5'($urandom_range(0, 3));
            bus.D_Tuse_rs = 2'($urandom_range(0, 3));
            bus.D_Tuse_rt = 2'($urandom_range(0, 3));
            bus.D_uses_md = 1'($urandom_range(0, 1));
            bus.D_eret = ($urandom_range(0, 3) == 0);
            bus.E_REG_write_number = 5'($urandom_range(0, 3));
            bus.E_REG_write_enable = 1'($urandom_range(0, 1));
            bus.E_Tnew = 2'($urandom_range(0, 3));
            bus.E_mtc0_epc = ($urandom_range(0, 3) == 0);
            bus.E_md_start = ($urandom_range(0, 11) == 0);
            bus.E_md_is_div = 1'($urandom_range(0, 1));
            bus.M_REG_write_number = 5'($urandom_range(0, 3));
            bus.M_REG_write_enable = 1'($urandom_range(0, 1));
            bus.M_Tnew = 2'($urandom_range(0, 3));
            bus.M_mtc0_epc = ($urandom_range(0, 3) == 0);
            bus.M_exc_req = ($urandom_range(0, 7) == 0);
        end

        next();
        drive_idle();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
